// File: rtl/wall_pkg.sv
// wall_pkg: shared types and defaults for the wall collider.
//  - COORD_W is the coordinate width used by every port and table field.
//  - SUM_W is the signed width of all collision arithmetic (never wraps).
//  - wall_t is one table slot, collider_state_e the query FSM states.
package wall_pkg;

    localparam int COORD_W       = 10;
    localparam int SUM_W         = COORD_W + 2;
    localparam int ADDR_W        = 25;

    localparam int NUM_WALLS_DEF = 8;
    localparam int KID_H_DEF     = 32;
    localparam int HB_L_DEF      = 10;
    localparam int HB_R_DEF      = 20;
    localparam int HB_T_DEF      = 10;
    localparam int TEX_BASE_DEF  = 1165248;

    typedef logic [COORD_W-1:0]      coord_t;
    typedef logic signed [SUM_W-1:0] sum_t;

    typedef struct packed {
        logic   valid;
        coord_t x;
        coord_t y;
        coord_t w;
        coord_t h;
    } wall_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} collider_state_e;

    // Unsigned screen coordinate into the signed arithmetic domain.
    function automatic sum_t widen(input coord_t v);
        return sum_t'({2'b00, v});
    endfunction

    // Two's-complement displacement into the signed arithmetic domain.
    function automatic sum_t sext(input coord_t v);
        return sum_t'({{2{v[COORD_W-1]}}, v});
    endfunction

endpackage

// File: rtl/wall_rect_check.sv
// wall_rect_check: combinational test of the kid hitbox and one draw pixel
// against a single wall rectangle.
//  wall            table slot under test
//  kid_x, kid_y    kid position at query time
//  fut_x, fut_y    kid position after the requested move (signed)
//  draw_x, draw_y  pixel being drawn
//  down/down_cand  landing on the wall top, corrected Kid_Y
//  up/up_cand      head bump on the wall bottom, corrected Kid_Y
//  ground          feet resting exactly on the wall top
//  side/side_cand  horizontal bump and corrected Kid_X (WALL_COLLIDER_HIT_X_EN only)
//  contains, addr  pixel inside the wall and its texture address
module wall_rect_check
    import wall_pkg::*;
#(
    parameter int KID_H    = KID_H_DEF,
    parameter int HB_L     = HB_L_DEF,
    parameter int HB_R     = HB_R_DEF,
    parameter int HB_T     = HB_T_DEF,
    parameter int TEX_BASE = TEX_BASE_DEF
) (
    input  wall_t              wall,
    input  coord_t             kid_x,
    input  coord_t             kid_y,
    input  sum_t               fut_x,
    input  sum_t               fut_y,
    input  coord_t             draw_x,
    input  coord_t             draw_y,
    output logic               down,
    output sum_t               down_cand,
    output logic               up,
    output sum_t               up_cand,
    output logic               ground,
`ifdef WALL_COLLIDER_HIT_X_EN
    output logic               side,
    output sum_t               side_cand,
`endif
    output logic               contains,
    output logic [ADDR_W-1:0]  addr
);

    sum_t       wx, wy, wx_end, wy_end, wy_below;
    sum_t       kx, ky, feet_now, feet_fut, head_now, head_fut;
    logic       overlap_fut, overlap_now;
    logic [4:0] dx_lo;
    coord_t     dy;

    // w and h are inclusive extents, so a zero size is still a 1-px line.
    assign wx       = widen(wall.x);
    assign wy       = widen(wall.y);
    assign wx_end   = wx + widen(wall.w);
    assign wy_end   = wy + widen(wall.h);
    assign wy_below = wy_end + sum_t'(1);

    assign kx       = widen(kid_x);
    assign ky       = widen(kid_y);
    assign feet_now = ky + sum_t'(KID_H);
    assign feet_fut = fut_y + sum_t'(KID_H);
    assign head_now = ky + sum_t'(HB_T);
    assign head_fut = fut_y + sum_t'(HB_T);

    assign overlap_fut = (fut_x + sum_t'(HB_R) >= wx) && (fut_x + sum_t'(HB_L) <= wx_end);
    assign overlap_now = (kx + sum_t'(HB_R) >= wx) && (kx + sum_t'(HB_L) <= wx_end);

    // Vertical hits require the move to cross the wall face, not just end inside it.
    assign down      = wall.valid && overlap_fut && (feet_now <= wy) && (feet_fut > wy);
    assign down_cand = wy - sum_t'(KID_H);
    assign up        = wall.valid && overlap_fut && (head_now >= wy_below) && (head_fut < wy_below);
    assign up_cand   = wy_below - sum_t'(HB_T);
    assign ground    = wall.valid && overlap_now && (feet_now == wy);

`ifdef WALL_COLLIDER_HIT_X_EN
    logic y_overlap, right_hit, left_hit;

    assign y_overlap = (feet_fut > wy) && (head_fut <= wy_end);
    assign right_hit = (fut_x > kx) && (kx + sum_t'(HB_R) < wx) && (fut_x + sum_t'(HB_R) >= wx);
    assign left_hit  = (fut_x < kx) && (kx + sum_t'(HB_L) > wx_end) && (fut_x + sum_t'(HB_L) <= wx_end);
    assign side      = wall.valid && y_overlap && (right_hit || left_hit);
    assign side_cand = right_hit ? (wx - sum_t'(HB_R) - sum_t'(1))
                                 : (wx_end + sum_t'(1) - sum_t'(HB_L));
`endif

    // The texture is a 32-px-wide tile; the low 5 bits of dx equal the
    // difference of the low 5 bits of the operands.
    assign contains = wall.valid
                   && (widen(draw_x) >= wx) && (widen(draw_x) <= wx_end)
                   && (widen(draw_y) >= wy) && (widen(draw_y) <= wy_end);
    assign dx_lo    = draw_x[4:0] - wall.x[4:0];
    assign dy       = draw_y - wall.y;
    assign addr     = ADDR_W'(TEX_BASE) + ADDR_W'(dx_lo) + ADDR_W'({dy, 5'b00000});

endmodule

// File: rtl/wall_collider.sv
// wall_collider: table of NUM_WALLS wall rectangles with a sequential
// per-frame collision query and a registered per-pixel wall lookup.
//  Clk, Reset            clock, synchronous active-high reset
//  wr_*                  table write port, honoured only while wr_ready
//  start, Kid_*, Move_*  query request and kid position/displacement
//  busy, done            scan in progress, 1-cycle result strobe
//  hit_y/y_land          landing result, hit_top/y_top head-bump result
//  ground                feet exactly on a wall top
//  DrawX, DrawY          pixel query; is_wall/wall_addr one cycle later
// Optional macro WALL_COLLIDER_HIT_X_EN adds hit_x/x_fix horizontal blocking.
// Coordinate width COORD_W is taken from wall_pkg.
module wall_collider
    import wall_pkg::*;
#(
    parameter int  NUM_WALLS = NUM_WALLS_DEF,
    parameter int  KID_H     = KID_H_DEF,
    parameter int  HB_L      = HB_L_DEF,
    parameter int  HB_R      = HB_R_DEF,
    parameter int  HB_T      = HB_T_DEF,
    parameter int  TEX_BASE  = TEX_BASE_DEF,
    localparam int IDX_W     = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic               wr_valid,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [COORD_W-1:0] wr_w,
    input  logic [COORD_W-1:0] wr_h,
    output logic               wr_ready,
    input  logic               start,
    input  logic [COORD_W-1:0] Kid_X,
    input  logic [COORD_W-1:0] Kid_Y,
    input  logic [COORD_W-1:0] Move_X,
    input  logic [COORD_W-1:0] Move_Y,
    output logic               busy,
    output logic               done,
    output logic               hit_y,
    output logic [COORD_W-1:0] y_land,
    output logic               hit_top,
    output logic [COORD_W-1:0] y_top,
    output logic               ground,
`ifdef WALL_COLLIDER_HIT_X_EN
    output logic               hit_x,
    output logic [COORD_W-1:0] x_fix,
`endif
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    output logic               is_wall,
    output logic [ADDR_W-1:0]  wall_addr
);

    collider_state_e      state;
    logic [IDX_W-1:0]     idx;
    wall_t                table_q [NUM_WALLS];
    coord_t               kid_x_q, kid_y_q;
    sum_t                 fut_x_q, fut_y_q;

    logic [NUM_WALLS-1:0] down_v, up_v, ground_v, contains_v;
    sum_t                 down_cand_v [NUM_WALLS];
    sum_t                 up_cand_v   [NUM_WALLS];
    logic [ADDR_W-1:0]    addr_v      [NUM_WALLS];

    logic                 acc_hit_y, acc_hit_top, acc_ground;
    sum_t                 acc_y_land, acc_y_top;
    logic                 nxt_hit_y, nxt_hit_top, nxt_ground;
    sum_t                 nxt_y_land, nxt_y_top;

    logic                 pix_hit;
    logic [ADDR_W-1:0]    pix_addr;

`ifdef WALL_COLLIDER_HIT_X_EN
    logic [NUM_WALLS-1:0] side_v;
    sum_t                 side_cand_v [NUM_WALLS];
    logic                 acc_hit_x, nxt_hit_x, moving_right;
    sum_t                 acc_x_fix, nxt_x_fix;
`endif

    // One checker per slot: the pixel path uses all of them every cycle,
    // the scan picks the one selected by idx.
    for (genvar g = 0; g < NUM_WALLS; g++) begin : g_chk
        wall_rect_check #(
            .KID_H(KID_H), .HB_L(HB_L), .HB_R(HB_R), .HB_T(HB_T), .TEX_BASE(TEX_BASE)
        ) u_chk (
            .wall      (table_q[g]),
            .kid_x     (kid_x_q),
            .kid_y     (kid_y_q),
            .fut_x     (fut_x_q),
            .fut_y     (fut_y_q),
            .draw_x    (DrawX),
            .draw_y    (DrawY),
            .down      (down_v[g]),
            .down_cand (down_cand_v[g]),
            .up        (up_v[g]),
            .up_cand   (up_cand_v[g]),
            .ground    (ground_v[g]),
`ifdef WALL_COLLIDER_HIT_X_EN
            .side      (side_v[g]),
            .side_cand (side_cand_v[g]),
`endif
            .contains  (contains_v[g]),
            .addr      (addr_v[g])
        );
    end

    // Fold the currently scanned wall into the running results:
    // lowest landing candidate, highest head-bump candidate.
    always_comb begin
        nxt_hit_y   = acc_hit_y;
        nxt_y_land  = acc_y_land;
        nxt_hit_top = acc_hit_top;
        nxt_y_top   = acc_y_top;
        nxt_ground  = acc_ground | ground_v[idx];
        if (down_v[idx] && (!acc_hit_y || (down_cand_v[idx] < acc_y_land))) begin
            nxt_hit_y  = 1'b1;
            nxt_y_land = down_cand_v[idx];
        end
        if (up_v[idx] && (!acc_hit_top || (up_cand_v[idx] > acc_y_top))) begin
            nxt_hit_top = 1'b1;
            nxt_y_top   = up_cand_v[idx];
        end
    end

`ifdef WALL_COLLIDER_HIT_X_EN
    // Nearest wall in the direction of travel gives the tightest correction.
    assign moving_right = fut_x_q > widen(kid_x_q);

    always_comb begin
        nxt_hit_x = acc_hit_x;
        nxt_x_fix = acc_x_fix;
        if (side_v[idx] && (!acc_hit_x ||
            (moving_right ? (side_cand_v[idx] < acc_x_fix) : (side_cand_v[idx] > acc_x_fix)))) begin
            nxt_hit_x = 1'b1;
            nxt_x_fix = side_cand_v[idx];
        end
    end
`endif

    // Query FSM; outputs are published together with done and held until
    // the next accepted start clears them.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            idx         <= '0;
            kid_x_q     <= '0;
            kid_y_q     <= '0;
            fut_x_q     <= '0;
            fut_y_q     <= '0;
            acc_hit_y   <= 1'b0;
            acc_y_land  <= '0;
            acc_hit_top <= 1'b0;
            acc_y_top   <= '0;
            acc_ground  <= 1'b0;
            wr_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit_y       <= 1'b0;
            y_land      <= '0;
            hit_top     <= 1'b0;
            y_top       <= '0;
            ground      <= 1'b0;
`ifdef WALL_COLLIDER_HIT_X_EN
            acc_hit_x   <= 1'b0;
            acc_x_fix   <= '0;
            hit_x       <= 1'b0;
            x_fix       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        kid_x_q     <= Kid_X;
                        kid_y_q     <= Kid_Y;
                        fut_x_q     <= widen(Kid_X) + sext(Move_X);
                        fut_y_q     <= widen(Kid_Y) + sext(Move_Y);
                        idx         <= '0;
                        acc_hit_y   <= 1'b0;
                        acc_y_land  <= '0;
                        acc_hit_top <= 1'b0;
                        acc_y_top   <= '0;
                        acc_ground  <= 1'b0;
                        hit_y       <= 1'b0;
                        y_land      <= '0;
                        hit_top     <= 1'b0;
                        y_top       <= '0;
                        ground      <= 1'b0;
`ifdef WALL_COLLIDER_HIT_X_EN
                        acc_hit_x   <= 1'b0;
                        acc_x_fix   <= '0;
                        hit_x       <= 1'b0;
                        x_fix       <= '0;
`endif
                        busy        <= 1'b1;
                        wr_ready    <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    acc_hit_y   <= nxt_hit_y;
                    acc_y_land  <= nxt_y_land;
                    acc_hit_top <= nxt_hit_top;
                    acc_y_top   <= nxt_y_top;
                    acc_ground  <= nxt_ground;
`ifdef WALL_COLLIDER_HIT_X_EN
                    acc_hit_x   <= nxt_hit_x;
                    acc_x_fix   <= nxt_x_fix;
`endif
                    if (idx == IDX_W'(NUM_WALLS - 1)) begin
                        hit_y   <= nxt_hit_y;
                        y_land  <= nxt_y_land[COORD_W-1:0];
                        hit_top <= nxt_hit_top;
                        y_top   <= nxt_y_top[COORD_W-1:0];
                        ground  <= nxt_ground;
`ifdef WALL_COLLIDER_HIT_X_EN
                        hit_x   <= nxt_hit_x;
                        x_fix   <= nxt_x_fix[COORD_W-1:0];
`endif
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    wr_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Writes are only taken while idle, so a running scan sees a frozen table.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_WALLS; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en && (state == IDLE) && (32'(wr_idx) < NUM_WALLS)) begin
            table_q[wr_idx] <= '{valid: wr_valid, x: wr_x, y: wr_y, w: wr_w, h: wr_h};
        end
    end

    // Lowest-index containing wall wins: iterate downwards so it is assigned last.
    always_comb begin
        pix_hit  = 1'b0;
        pix_addr = '0;
        for (int i = NUM_WALLS - 1; i >= 0; i--) begin
            if (contains_v[i]) begin
                pix_hit  = 1'b1;
                pix_addr = addr_v[i];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            is_wall   <= 1'b0;
            wall_addr <= '0;
        end else begin
            is_wall   <= pix_hit;
            wall_addr <= pix_addr;
        end
    end

endmodule

// File: tb/tb_wall_collider.sv
// tb_wall_collider: scoreboard bench for wall_collider (default parameters).
// Expected query results are queued when a start is driven and popped when
// done strobes; pixel lookups are compared one cycle after DrawX/DrawY change.
// Build with WALL_COLLIDER_HIT_X_EN to also exercise hit_x/x_fix.
module tb_wall_collider;

    localparam int N   = 8;
    localparam int TEX = 1165248;

    typedef struct {
        int hit_y;
        int y_land;
        int hit_top;
        int y_top;
        int ground;
        int hit_x;
        int x_fix;
        bit chk_x;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_idx = '0;
    logic        wr_valid = 1'b0;
    logic [9:0]  wr_x = '0, wr_y = '0, wr_w = '0, wr_h = '0;
    logic        wr_ready;
    logic        start = 1'b0;
    logic [9:0]  Kid_X = '0, Kid_Y = '0, Move_X = '0, Move_Y = '0;
    logic        busy, done, hit_y, hit_top, ground;
    logic [9:0]  y_land, y_top;
`ifdef WALL_COLLIDER_HIT_X_EN
    logic        hit_x;
    logic [9:0]  x_fix;
`endif
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        is_wall;
    logic [24:0] wall_addr;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   mValid[N], mX[N], mY[N], mW[N], mH[N];

    wall_collider dut (
        .Clk(Clk), .Reset(Reset),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
        .wr_x(wr_x), .wr_y(wr_y), .wr_w(wr_w), .wr_h(wr_h), .wr_ready(wr_ready),
        .start(start), .Kid_X(Kid_X), .Kid_Y(Kid_Y), .Move_X(Move_X), .Move_Y(Move_Y),
        .busy(busy), .done(done),
        .hit_y(hit_y), .y_land(y_land), .hit_top(hit_top), .y_top(y_top), .ground(ground),
`ifdef WALL_COLLIDER_HIT_X_EN
        .hit_x(hit_x), .x_fix(x_fix),
`endif
        .DrawX(DrawX), .DrawY(DrawY), .is_wall(is_wall), .wall_addr(wall_addr)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic exp_t mkExp(input int hy, input int yl, input int ht, input int yt, input int gr);
        exp_t e;
        e = '{default: 0};
        e.hit_y = hy; e.y_land = yl; e.hit_top = ht; e.y_top = yt; e.ground = gr;
        return e;
    endfunction

    // Reference model of the collision query over the bench's copy of the table.
    function automatic exp_t modelQuery(input int kx, input int ky, input int mx, input int my);
        exp_t r;
        int fx, fy, xe, ye, yl, yt;
        r = '{default: 0};
        fx = kx + mx; fy = ky + my; yl = 0; yt = 0;
        for (int i = 0; i < N; i++) begin
            if (mValid[i] != 0) begin
                xe = mX[i] + mW[i];
                ye = mY[i] + mH[i];
                if (fx + 20 >= mX[i] && fx + 10 <= xe) begin
                    if (ky + 32 <= mY[i] && fy + 32 > mY[i]) begin
                        if (r.hit_y == 0 || mY[i] - 32 < yl) yl = mY[i] - 32;
                        r.hit_y = 1;
                    end
                    if (ky + 10 >= ye + 1 && fy + 10 < ye + 1) begin
                        if (r.hit_top == 0 || ye + 1 - 10 > yt) yt = ye + 1 - 10;
                        r.hit_top = 1;
                    end
                end
                if (ky + 32 == mY[i] && kx + 20 >= mX[i] && kx + 10 <= xe) r.ground = 1;
            end
        end
        r.y_land = yl & 1023;
        r.y_top  = yt & 1023;
        return r;
    endfunction

    task automatic writeWall(input int idx, input int v, input int x, input int y, input int w, input int h);
        @(negedge Clk);
        checkOutput("wr_ready_idle", wr_ready, 1);
        wr_en = 1'b1; wr_idx = 3'(idx); wr_valid = v[0];
        wr_x = 10'(x); wr_y = 10'(y); wr_w = 10'(w); wr_h = 10'(h);
        @(posedge Clk); #1;
        wr_en = 1'b0;
        mValid[idx] = v; mX[idx] = x; mY[idx] = y; mW[idx] = w; mH[idx] = h;
    endtask

    task automatic compareResult(input exp_t e);
        checkOutput("hit_y", hit_y, e.hit_y);
        checkOutput("y_land", y_land, e.y_land);
        checkOutput("hit_top", hit_top, e.hit_top);
        checkOutput("y_top", y_top, e.y_top);
        checkOutput("ground", ground, e.ground);
`ifdef WALL_COLLIDER_HIT_X_EN
        if (e.chk_x) begin
            checkOutput("hit_x", hit_x, e.hit_x);
            checkOutput("x_fix", x_fix, e.x_fix);
        end
`endif
    endtask

    task automatic waitDone(input int already, output int cycles);
        cycles = already;
        while (!done && cycles < 4 * N) begin
            @(posedge Clk); #1;
            cycles++;
        end
    endtask

    task automatic applyStimulus(input int kx, input int ky, input int mx, input int my, input exp_t e);
        int cycles;
        exp_t got;
        @(negedge Clk);
        Kid_X = 10'(kx); Kid_Y = 10'(ky); Move_X = 10'(mx); Move_Y = 10'(my);
        start = 1'b1;
        expQ.push_back(e);
        @(posedge Clk); #1;
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("hit_y_cleared", hit_y, 0);
        checkOutput("y_land_cleared", y_land, 0);
        waitDone(0, cycles);
        checkOutput("done_latency", cycles, N);
        if (expQ.size() > 0) begin
            got = expQ.pop_front();
            compareResult(got);
        end
        @(posedge Clk); #1;
        checkOutput("done_single_cycle", done, 0);
        checkOutput("wr_ready_back", wr_ready, 1);
    endtask

    task automatic samplePixel(input int px, input int py);
        @(negedge Clk);
        DrawX = 10'(px); DrawY = 10'(py);
        @(posedge Clk); #1;
    endtask

    task automatic checkPixel(input int px, input int py);
        int ew, ea;
        ew = 0; ea = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mValid[i] != 0 && px >= mX[i] && px <= mX[i] + mW[i] &&
                py >= mY[i] && py <= mY[i] + mH[i]) begin
                ew = 1;
                ea = TEX + ((px - mX[i]) & 31) + (py - mY[i]) * 32;
            end
        end
        samplePixel(px, py);
        checkOutput("is_wall", is_wall, ew);
        checkOutput("wall_addr", wall_addr, ea);
    endtask

    initial begin
        int cycles, dones, kx, ky, mx, my;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            mValid[i] = 0; mX[i] = 0; mY[i] = 0; mW[i] = 0; mH[i] = 0;
        end

        // Reset state.
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        checkOutput("rst_wr_ready", wr_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_hit_y", hit_y, 0);
        checkOutput("rst_ground", ground, 0);
        checkOutput("rst_is_wall", is_wall, 0);
        checkOutput("rst_wall_addr", wall_addr, 0);

        // Floor landing, ledge nearer than floor, ceiling bump, standing on floor.
        writeWall(0, 1, 0, 448, 639, 31);
        applyStimulus(100, 410, 0, 10, mkExp(1, 416, 0, 0, 0));
        writeWall(1, 1, 219, 382, 200, 31);
        applyStimulus(300, 340, 0, 20, mkExp(1, 350, 0, 0, 0));
        writeWall(2, 1, 0, 138, 500, 31);
        applyStimulus(50, 165, 0, -10, mkExp(0, 0, 1, 160, 0));
        applyStimulus(100, 416, 0, 0, mkExp(0, 0, 0, 0, 1));
        samplePixel(5, 450);
        checkOutput("floor_is_wall", is_wall, 1);
        checkOutput("floor_addr", wall_addr, 1165317);

        // Boundaries: feet ending exactly on the top is no hit; hitbox edge touching counts.
        applyStimulus(100, 400, 0, 16, mkExp(0, 0, 0, 0, 0));
        applyStimulus(100, 400, 0, 17, mkExp(1, 416, 0, 0, 0));
        applyStimulus(199, 340, 0, 20, mkExp(1, 350, 0, 0, 0));
        applyStimulus(198, 340, 0, 20, mkExp(0, 0, 0, 0, 0));

        // Pixel priority, 1-px wall, deletion.
        writeWall(3, 1, 10, 440, 20, 20);
        samplePixel(15, 450);
        checkOutput("prio_addr", wall_addr, 1165327);
        writeWall(4, 1, 600, 100, 0, 0);
        checkPixel(600, 100);
        checkPixel(601, 100);
        writeWall(3, 0, 10, 440, 20, 20);
        checkPixel(15, 445);

        // Randomised queries and pixels against the model.
        for (int n = 0; n < 6; n++) begin
            kx = $urandom_range(0, 600);
            ky = $urandom_range(100, 440);
            mx = int'($urandom_range(0, 40)) - 20;
            my = int'($urandom_range(0, 60)) - 30;
            applyStimulus(kx, ky, mx, my, modelQuery(kx, ky, mx, my));
        end
        for (int n = 0; n < 6; n++) begin
            checkPixel($urandom_range(0, 639), $urandom_range(370, 479));
        end

`ifdef WALL_COLLIDER_HIT_X_EN
        writeWall(5, 1, 200, 300, 31, 100);
        e = modelQuery(175, 320, 10, 0);
        e.hit_x = 1; e.x_fix = 179; e.chk_x = 1'b1;
        applyStimulus(175, 320, 10, 0, e);
        writeWall(5, 0, 200, 300, 31, 100);
`endif

        // A second start and a table write during SCAN are both ignored.
        e = modelQuery(100, 410, 0, 10);
        @(negedge Clk);
        Kid_X = 10'd100; Kid_Y = 10'd410; Move_X = 10'd0; Move_Y = 10'd10;
        start = 1'b1;
        expQ.push_back(e);
        @(posedge Clk); #1;
        start = 1'b0;
        @(posedge Clk); #1;
        checkOutput("wr_ready_scan", wr_ready, 0);
        start = 1'b1; Kid_X = 10'd300; Kid_Y = 10'd340; Move_Y = 10'd20;
        wr_en = 1'b1; wr_idx = 3'd6; wr_valid = 1'b1;
        wr_x = 10'd700; wr_y = 10'd700; wr_w = 10'd10; wr_h = 10'd10;
        @(posedge Clk); #1;
        start = 1'b0; wr_en = 1'b0;
        waitDone(2, cycles);
        checkOutput("scan_busy_latency", cycles, N);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            compareResult(e);
        end
        dones = 0;
        repeat (N + 3) begin
            @(posedge Clk); #1;
            if (done) dones++;
        end
        checkOutput("ignored_start_no_done", dones, 0);
        checkPixel(705, 705);

        // Reset while scanning idx 3 aborts without a done pulse.
        @(negedge Clk);
        Kid_X = 10'd100; Kid_Y = 10'd410; Move_X = 10'd0; Move_Y = 10'd10;
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge Clk); #1;
        end
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        for (int i = 0; i < N; i++) mValid[i] = 0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_wr_ready", wr_ready, 1);
        checkOutput("abort_hit_y", hit_y, 0);
        checkOutput("abort_y_land", y_land, 0);
        dones = 0;
        repeat (N + 3) begin
            @(posedge Clk); #1;
            if (done) dones++;
        end
        checkOutput("abort_no_done", dones, 0);
        checkPixel(5, 450);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
